// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single RAM port between instruction fetch and the memory stage.
// One transaction is in flight at a time. The granted request is registered
// onto the arb_ram_* outputs and held until the RAM signals ready or the wait
// counter times out. The requester then gets its read data and a one-cycle
// completion pulse. Data accesses win arbitration unless fetch has already
// been passed over STARVE_LIMIT times in a row.

module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,   // 1..15
  parameter int unsigned TIMEOUT      = 63   // 1..255
) (
  input  logic        clock,
  input  logic        reset,

  // Fetch requester
  input  logic        if_arb_req,
  input  logic [31:0] if_arb_addr,
  output logic [31:0] arb_if_rdata,
  output logic        arb_if_valid,
  output logic        arb_if_stall,

  // Memory-stage requester
  input  logic        mem_arb_req,
  input  logic        mem_arb_we,
  input  logic [31:0] mem_arb_addr,
  input  logic [31:0] mem_arb_wdata,
  input  logic [3:0]  mem_arb_be,
  output logic [31:0] arb_mem_rdata,
  output logic        arb_mem_done,
  output logic        arb_mem_stall,

  // RAM port
  output logic        arb_ram_req,
  output logic        arb_ram_we,
  output logic [31:0] arb_ram_addr,
  output logic [31:0] arb_ram_wdata,
  output logic [3:0]  arb_ram_be,
  input  logic        ram_arb_ready,
  input  logic [31:0] ram_arb_rdata,

  output logic        arb_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM   = 4'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic        ram_req_q, ram_req_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]  ram_be_q, ram_be_d;

  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        mem_done_q, mem_done_d;
  logic        err_q, err_d;

  logic        pulse_active;
  logic        mem_wins;
  logic        grant_mem;
  logic        grant_if;
  logic        busy;
  logic        timed_out;
  logic        finish;
  logic [31:0] finish_data;

  // Arbitration is only open in IDLE and never during the completion-pulse
  // cycle: the requester still shows its old request then, and granting it
  // would replay a transaction that has already completed.
  assign pulse_active = if_valid_q | mem_done_q;
  assign mem_wins     = mem_arb_req & (~if_arb_req | (starve_cnt_q < STARVE_LIM));
  assign grant_mem    = (state_q == IDLE) & ~pulse_active & mem_wins;
  assign grant_if     = (state_q == IDLE) & ~pulse_active & ~mem_wins & if_arb_req;

  // A transaction ends on ready, or on the cycle the wait counter would reach
  // TIMEOUT. Ready takes precedence, so a late ready is never flagged as an error.
  assign busy        = (state_q == IF_BUSY) | (state_q == MEM_BUSY);
  assign timed_out   = busy & ~ram_arb_ready & (wait_cnt_q == TIMEOUT_LAST);
  assign finish      = busy & (ram_arb_ready | timed_out);
  assign finish_data = (timed_out | ram_we_q) ? 32'h0 : ram_arb_rdata;

  // Next-state logic for the transaction FSM.
  always_comb begin
    // NOTE: every signal written here is given a default first so that no
    // path leaves it unassigned; a missing default infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d = MEM_BUSY;
        end else if (grant_if) begin
          state_d = IF_BUSY;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (finish) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: grant capture, completion capture, counters, flags.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    ram_req_d    = ram_req_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_be_d     = ram_be_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_valid_d   = 1'b0;
    mem_done_d   = 1'b0;
    err_d        = err_q;

    if (grant_mem) begin
      ram_req_d   = 1'b1;
      ram_we_d    = mem_arb_we;
      ram_addr_d  = mem_arb_addr;
      ram_wdata_d = mem_arb_wdata;
      ram_be_d    = mem_arb_be;
      wait_cnt_d  = 8'd0;
      // Only a grant that actually passes fetch over counts toward starvation.
      if (if_arb_req && (starve_cnt_q != 4'hF)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else if (grant_if) begin
      ram_req_d    = 1'b1;
      ram_we_d     = 1'b0;
      ram_addr_d   = if_arb_addr;
      ram_wdata_d  = 32'h0;
      ram_be_d     = 4'hF;
      wait_cnt_d   = 8'd0;
      starve_cnt_d = 4'd0;
    end

    if (busy && !ram_arb_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end

    if (finish) begin
      ram_req_d = 1'b0;
      if (state_q == IF_BUSY) begin
        if_rdata_d = finish_data;
        if_valid_d = 1'b1;
      end else begin
        mem_rdata_d = finish_data;
        mem_done_d  = 1'b1;
      end
      if (timed_out) begin
        err_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset clears everything including the RAM
  // request, so a transaction interrupted by reset produces no pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      wait_cnt_q   <= 8'd0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= 32'h0;
      ram_wdata_q  <= 32'h0;
      ram_be_q     <= 4'h0;
      if_rdata_q   <= 32'h0;
      mem_rdata_q  <= 32'h0;
      if_valid_q   <= 1'b0;
      mem_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      ram_req_q    <= ram_req_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_be_q     <= ram_be_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_valid_q   <= if_valid_d;
      mem_done_q   <= mem_done_d;
      err_q        <= err_d;
    end
  end

  assign arb_ram_req   = ram_req_q;
  assign arb_ram_we    = ram_we_q;
  assign arb_ram_addr  = ram_addr_q;
  assign arb_ram_wdata = ram_wdata_q;
  assign arb_ram_be    = ram_be_q;

  assign arb_if_rdata  = if_rdata_q;
  assign arb_if_valid  = if_valid_q;
  assign arb_mem_rdata = mem_rdata_q;
  assign arb_mem_done  = mem_done_q;
  assign arb_err       = err_q;

  // Stalls follow the live request so a requester freezes the same cycle it asks.
  assign arb_if_stall  = if_arb_req & ~if_valid_q;
  assign arb_mem_stall = mem_arb_req & ~mem_done_q;

endmodule
